fetch_unit: RTL and testbench

- Instruction-fetch stage directly upstream of the main control decoder.
- Holds the PC and drives a req/ack instruction-memory handshake.
- Latches the fetched word into an instruction register and presents opcode [31:26] to the decoder.
- Consumes the decoder's 2-bit PC-source select, plus ALU zero and register data, to choose the next PC.

---
 rtl/fetch_unit.sv | 143 ++++++++++++++
 tb/tb_fetch_unit.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, req/ack instruction-memory handshake, instruction register.
// Optional FETCH_PERF_CNT_EN adds retired/redirect performance counters.
module fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    input  logic              imem_ack,
    input  logic              stall,
    input  logic [1:0]        PCsrc,
    input  logic              zero,
    input  logic [ADDR_W-1:0] jr_target,
    output logic [31:0]       instr,
    output logic [5:0]        opcode,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]       retired_cnt,
    output logic [31:0]       redirect_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        EXEC
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       instr_q, instr_d;
    logic              imem_req_q, imem_req_d;
    logic              instr_valid_q, instr_valid_d;
    logic [ADDR_W-1:0] next_pc;
    logic              retire;
    logic              unused_jr_bits;

    assign pc_plus4       = pc_q + ADDR_W'(4);
    assign unused_jr_bits = ^jr_target[1:0];

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        next_pc = pc_plus4;
        unique case (PCsrc)
            2'b01:   if (zero) next_pc = pc_plus4 + {{(ADDR_W-18){instr_q[15]}}, instr_q[15:0], 2'b00};
            2'b10:   next_pc = {pc_plus4[ADDR_W-1:28], instr_q[25:0], 2'b00};
            2'b11:   next_pc = {jr_target[ADDR_W-1:2], 2'b00};
            default: next_pc = pc_plus4;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        imem_req_d    = imem_req_q;
        instr_valid_d = instr_valid_q;
        retire        = 1'b0;
        unique case (state_q)
            IDLE: begin
                state_d    = FETCH;
                imem_req_d = 1'b1;
            end
            FETCH: begin
                // Ack is accepted even in the first cycle req is high (zero-wait memory).
                if (imem_ack) begin
                    instr_d       = imem_rdata;
                    state_d       = EXEC;
                    imem_req_d    = 1'b0;
                    instr_valid_d = 1'b1;
                end
            end
            EXEC: begin
                if (!stall) begin
                    pc_d          = next_pc;
                    state_d       = FETCH;
                    imem_req_d    = 1'b1;
                    instr_valid_d = 1'b0;
                    retire        = 1'b1;
                end
            end
            default: begin
                state_d       = IDLE;
                imem_req_d    = 1'b0;
                instr_valid_d = 1'b0;
            end
        endcase
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] retired_cnt_q, retired_cnt_d;
    logic [31:0] redirect_cnt_q, redirect_cnt_d;

    always_comb begin
        retired_cnt_d  = retired_cnt_q  + 32'(retire);
        redirect_cnt_d = redirect_cnt_q + 32'(retire && (next_pc != pc_plus4));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_cnt_q  <= '0;
            redirect_cnt_q <= '0;
        end else begin
            retired_cnt_q  <= retired_cnt_d;
            redirect_cnt_q <= redirect_cnt_d;
        end
    end

    assign retired_cnt  = retired_cnt_q;
    assign redirect_cnt = redirect_cnt_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (!rst_n) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            instr_q       <= '0;
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            imem_req_q    <= imem_req_d;
            instr_valid_q <= instr_valid_d;
        end
    end

    assign imem_req    = imem_req_q;
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign instr       = instr_q;
    assign opcode      = instr_q[31:26];
    assign instr_valid = instr_valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by randomized instruction streams,
// checked against a PC/instruction model kept in the bench.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        imem_ack = 1'b0;
    logic        stall = 1'b0;
    logic [1:0]  PCsrc = 2'b00;
    logic        zero = 1'b0;
    logic [31:0] jr_target = '0;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] retired_cnt;
    logic [31:0] redirect_cnt;
`endif

    fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_ack    (imem_ack),
        .stall       (stall),
        .PCsrc       (PCsrc),
        .zero        (zero),
        .jr_target   (jr_target),
        .instr       (instr),
        .opcode      (opcode),
        .instr_valid (instr_valid),
        .pc          (pc),
        .pc_plus4    (pc_plus4)
`ifdef FETCH_PERF_CNT_EN
        ,
        .retired_cnt (retired_cnt),
        .redirect_cnt(redirect_cnt)
`endif
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] m_pc = 32'h0;
    logic [31:0] m_retired = 0;
    logic [31:0] m_redirect = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Next-PC rules written as plain arithmetic on the model PC.
    function automatic logic [31:0] model_next(input logic [31:0] cur, input logic [31:0] w,
                                               input logic [1:0] src, input logic z,
                                               input logic [31:0] jr);
        logic signed [15:0] imm;
        int                 off;
        imm = w[15:0];
        off = imm;
        case (src)
            2'b01:   return z ? cur + 32'd4 + 32'(off * 4) : cur + 32'd4;
            2'b10:   return ((cur + 32'd4) & 32'hF000_0000) | ((w & 32'h03FF_FFFF) * 32'd4);
            2'b11:   return jr & ~32'd3;
            default: return cur + 32'd4;
        endcase
    endfunction

    task automatic wait_req();
        int n = 0;
        while (imem_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("req_timeout", {31'b0, imem_req}, 32'd1);
    endtask

    // One full instruction: fetch with ack delay, EXEC with stall, then redirect via PCsrc.
    task automatic run_instr(input logic [31:0] word, input int delay, input int stalls,
                             input logic [1:0] src, input logic z, input logic [31:0] jr);
        logic [31:0] nxt;
        wait_req();
        check("fetch_addr", imem_addr, m_pc);
        check("fetch_valid_low", {31'b0, instr_valid}, 32'd0);
        for (int i = 0; i < delay; i++) begin
            imem_ack = 1'b0;
            @(negedge clk);
            check("req_held", {31'b0, imem_req}, 32'd1);
        end
        imem_ack   = 1'b1;
        imem_rdata = word;
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        check("exec_valid", {31'b0, instr_valid}, 32'd1);
        check("exec_instr", instr, word);
        check("exec_opcode", {26'b0, opcode}, {26'b0, word[31:26]});
        check("exec_pc", pc, m_pc);
        check("exec_pc_plus4", pc_plus4, m_pc + 32'd4);
        check("exec_req_low", {31'b0, imem_req}, 32'd0);
`ifdef FETCH_PERF_CNT_EN
        check("retired_cnt", retired_cnt, m_retired);
        check("redirect_cnt", redirect_cnt, m_redirect);
`endif
        for (int i = 0; i < stalls; i++) begin
            stall      = 1'b1;
            imem_ack   = 1'($urandom_range(0, 1));
            imem_rdata = $urandom;
            PCsrc      = 2'($urandom);
            zero       = 1'($urandom);
            jr_target  = $urandom;
            @(negedge clk);
            check("stall_pc", pc, m_pc);
            check("stall_instr", instr, word);
            check("stall_valid", {31'b0, instr_valid}, 32'd1);
            check("stall_req_low", {31'b0, imem_req}, 32'd0);
        end
        stall     = 1'b0;
        imem_ack  = 1'b0;
        PCsrc     = src;
        zero      = z;
        jr_target = jr;
        @(negedge clk);
        nxt = model_next(m_pc, word, src, z, jr);
        m_retired++;
        if (nxt != m_pc + 32'd4) m_redirect++;
        m_pc      = nxt;
        PCsrc     = 2'($urandom);
        zero      = 1'($urandom);
        jr_target = $urandom;
    endtask

    initial begin
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_pc", pc, 32'h0);
        check("rst_instr", instr, 32'h0);
        check("rst_req", {31'b0, imem_req}, 32'd0);
        check("rst_valid", {31'b0, instr_valid}, 32'd0);
        rst_n = 1'b1;

        // Sequential stream, zero-wait memory.
        run_instr(32'h0, 0, 0, 2'b00, 1'b0, 32'h0);
        check("seq_addr_4", imem_addr, 32'h4);
        run_instr(32'h0, 0, 0, 2'b00, 1'b0, 32'h0);
        check("seq_addr_8", imem_addr, 32'h8);
        run_instr(32'h0, 0, 0, 2'b00, 1'b0, 32'h0);
        run_instr(32'h0, 0, 0, 2'b00, 1'b0, 32'h0);
        check("seq_addr_10", imem_addr, 32'h10);

        // Branch taken / not taken from 0x10.
        run_instr(32'h2000_0003, 0, 0, 2'b01, 1'b1, 32'h0);
        check("branch_taken", imem_addr, 32'h20);
        run_instr(32'h0, 0, 0, 2'b11, 1'b0, 32'h0000_0013);
        check("jr_back_10", imem_addr, 32'h10);
        run_instr(32'h2000_0003, 0, 0, 2'b01, 1'b0, 32'h0);
        check("branch_not_taken", imem_addr, 32'h14);

        // Jump keeps upper nibble of pc+4.
        run_instr(32'h0, 0, 0, 2'b11, 1'b0, 32'h8000_0003);
        check("jr_to_8000", imem_addr, 32'h8000_0000);
        run_instr(32'h0800_0040, 0, 0, 2'b10, 1'b0, 32'h0);
        check("jump_region", imem_addr, 32'h8000_0100);
        run_instr(32'h0, 0, 0, 2'b11, 1'b0, 32'h0000_1237);
        check("jr_align", imem_addr, 32'h0000_1234);

        // Slow memory plus stall.
        run_instr(32'hDEAD_BEEF, 3, 2, 2'b00, 1'b0, 32'h0);
        check("slow_stall_addr", imem_addr, 32'h0000_1238);

        // Randomized stream.
        for (int k = 0; k < 60; k++) begin
            run_instr($urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                      2'($urandom), 1'($urandom), $urandom);
        end

        // Reset while fetching with a simultaneous ack.
        wait_req();
        imem_ack   = 1'b1;
        imem_rdata = 32'hCAFE_F00D;
        rst_n      = 1'b0;
        #1;
        check("midrst_pc", pc, 32'h0);
        check("midrst_instr", instr, 32'h0);
        check("midrst_valid", {31'b0, instr_valid}, 32'd0);
        check("midrst_req", {31'b0, imem_req}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("postrst_req", {31'b0, imem_req}, 32'd1);
        check("postrst_addr", imem_addr, 32'h0);
        check("postrst_instr", instr, 32'h0);
        check("postrst_valid", {31'b0, instr_valid}, 32'd0);
        imem_ack   = 1'b0;
        m_pc       = 32'h0;
        m_retired  = 0;
        m_redirect = 0;
        run_instr(32'h1234_5678, 1, 1, 2'b00, 1'b0, 32'h0);
        check("postrst_seq", imem_addr, 32'h4);
        run_instr(32'h1234_5678, 0, 0, 2'b01, 1'b1, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
